// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared encodings for the memory/writeback stage
//   ResultSrc encodings, MMIO window default, bus FSM states, bus error read data.
package riscv_pipe_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [3:0] MMIO_NIBBLE_DEF = 4'h4;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } bus_state_t;

endpackage

// File: rtl/mem_wb_cycle_if.sv
// rtl/mem_wb_cycle_if.sv - MMIO req/ack bus between the memory stage and the SPI peripheral
//   master: drives bus_req/bus_we/bus_addr/bus_wdata/bus_err, receives bus_rdata/bus_ack
//   slave : the peripheral side
interface mem_wb_cycle_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        output bus_err,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        input  bus_err,
        output bus_rdata,
        output bus_ack
    );

endinterface

// File: rtl/mem_wb_cycle_data_memory.sv
// rtl/mem_wb_cycle_data_memory.sv - local word-addressed data memory, sync write, async read
//   clk       in   clock
//   i_we      in   write enable (sampled on posedge)
//   i_idx     in   word index
//   i_wdata   in   write data
//   o_rdata   out  combinational read data at i_idx
//   Contents are deliberately not reset.
module data_memory #(
    parameter int WORDS = 64,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mem_wb_cycle.sv
// rtl/mem_wb_cycle.sv - RV32 memory + writeback stage with local dmem and stalling MMIO bus
//   Optional bus watchdog: define MEM_WB_TIMEOUT_EN (adds parameter TIMEOUT_CYCLES).
//   clk, rst (async, active-low)
//   RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M : M-stage inputs
//   StallM     : stall request to F/D/E/M registers
//   bus        : MMIO req/ack bus (master modport)
//   RegWriteW, RDW, ResultW : register file write port
module mem_wb_cycle
    import riscv_pipe_pkg::*;
#(
    parameter int         DMEM_WORDS  = 64,
    parameter logic [3:0] MMIO_NIBBLE = MMIO_NIBBLE_DEF
`ifdef MEM_WB_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CYCLES = 255
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RegWriteM,
    input  logic               MemWriteM,
    input  logic [1:0]         ResultSrcM,
    input  logic [4:0]         RD_M,
    input  logic [31:0]        ALUResultM,
    input  logic [31:0]        WriteDataM,
    input  logic [31:0]        PCPlus4M,
    output logic               StallM,
    mem_wb_cycle_if.master     bus,
    output logic               RegWriteW,
    output logic [4:0]         RDW,
    output logic [31:0]        ResultW
);

    localparam int AW = $clog2(DMEM_WORDS);

    bus_state_t  r_state;
    bus_state_t  w_state_nxt;

    logic        w_mmio;
    logic        w_is_mem;
    logic        w_req;
    logic        w_ack_raw;
    logic        w_timeout;
    logic        w_dmem_we;
    logic [31:0] w_dmem_rdata;
    logic [31:0] w_load_data;
    logic [31:0] w_result;

    logic        r_regwrite_w;
    logic [4:0]  r_rd_w;
    logic [31:0] r_result_w;

    assign w_mmio   = (ALUResultM[31:28] == MMIO_NIBBLE);
    assign w_is_mem = MemWriteM | (ResultSrcM == RES_MEM);

    // Local memory: upper address bits are simply dropped, so addresses wrap.
    assign w_dmem_we = ~w_mmio & MemWriteM;

    data_memory #(
        .WORDS (DMEM_WORDS)
    ) u_dmem (
        .clk     (clk),
        .i_we    (w_dmem_we),
        .i_idx   (ALUResultM[AW+1:2]),
        .i_wdata (WriteDataM),
        .o_rdata (w_dmem_rdata)
    );

`ifdef MEM_WB_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [WD_W-1:0] r_wdog;

    // Fires during the TIMEOUT_CYCLES-th WAIT cycle, completing the access in that cycle.
    assign w_timeout = (r_state == WAIT) && !bus.bus_ack
                       && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog <= '0;
        end else if ((r_state == WAIT) && !bus.bus_ack && !w_timeout) begin
            r_wdog <= r_wdog + 1'b1;
        end else begin
            r_wdog <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // A watchdog expiry is treated exactly like an ack from the peripheral.
    assign w_ack_raw = bus.bus_ack | w_timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_req = w_mmio & w_is_mem;
                if (w_req && !w_ack_raw) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                w_req = 1'b1;
                if (w_ack_raw) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // Reset must silence the bus even while M inputs still describe an MMIO access.
        w_req = w_req & rst;
    end

    assign bus.bus_req   = w_req;
    assign bus.bus_we    = MemWriteM;
    assign bus.bus_addr  = ALUResultM;
    assign bus.bus_wdata = WriteDataM;
    assign bus.bus_err   = w_timeout;

    assign StallM = w_req & ~w_ack_raw;

    assign w_load_data = w_mmio ? (w_timeout ? BUS_ERR_DATA : bus.bus_rdata) : w_dmem_rdata;

    always_comb begin
        w_result = 32'h0;
        unique case (ResultSrcM)
            RES_ALU: w_result = ALUResultM;
            RES_MEM: w_result = w_load_data;
            RES_PC4: w_result = PCPlus4M;
            default: w_result = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_regwrite_w <= 1'b0;
            r_rd_w       <= 5'd0;
            r_result_w   <= 32'h0;
        end else if (StallM) begin
            // Bubble: writeback disabled, destination and data held.
            r_regwrite_w <= 1'b0;
        end else begin
            r_regwrite_w <= RegWriteM;
            r_rd_w       <= RD_M;
            r_result_w   <= w_result;
        end
    end

    assign RegWriteW = r_regwrite_w;
    assign RDW       = r_rd_w;
    assign ResultW   = r_result_w;

endmodule

// File: tb/tb_mem_wb_cycle.sv
// tb/tb_mem_wb_cycle.sv - directed self-checking bench for mem_wb_cycle
module tb_mem_wb_cycle;

    logic        clk;
    logic        rst;
    logic        RegWriteM;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic        StallM;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;

    int n_checks = 0;
    int n_errors = 0;

    mem_wb_cycle_if bus_if ();

    mem_wb_cycle #(
        .DMEM_WORDS     (64),
        .MMIO_NIBBLE    (4'h4)
`ifdef MEM_WB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (4)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .RD_M       (RD_M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .PCPlus4M   (PCPlus4M),
        .StallM     (StallM),
        .bus        (bus_if.master),
        .RegWriteW  (RegWriteW),
        .RDW        (RDW),
        .ResultW    (ResultW)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input logic rw, input logic mw, input logic [1:0] src,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc);
        RegWriteM  = rw;
        MemWriteM  = mw;
        ResultSrcM = src;
        RD_M       = rd;
        ALUResultM = alu;
        WriteDataM = wd;
        PCPlus4M   = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        set_m(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;

        #12;
        chk("rst_regwrite", 32'(RegWriteW), 32'd0);
        chk("rst_rdw", 32'(RDW), 32'd0);
        chk("rst_result", ResultW, 32'h0);
        chk("rst_stall", 32'(StallM), 32'd0);
        chk("rst_req", 32'(bus_if.bus_req), 32'd0);
        chk("rst_err", 32'(bus_if.bus_err), 32'd0);
        tick();
        rst = 1'b1;

        // local sw x5 @0x10 then lw x6 @0x10
        set_m(1'b0, 1'b1, 2'b00, 5'd0, 32'h10, 32'h1234_5678, 32'h0);
        @(negedge clk);
        chk("sw_stall", 32'(StallM), 32'd0);
        chk("sw_req", 32'(bus_if.bus_req), 32'd0);
        tick();
        set_m(1'b1, 1'b0, 2'b01, 5'd6, 32'h10, 32'h0, 32'h0);
        @(negedge clk);
        chk("lw_stall", 32'(StallM), 32'd0);
        tick();
        chk("lw_regwrite", 32'(RegWriteW), 32'd1);
        chk("lw_rdw", 32'(RDW), 32'd6);
        chk("lw_result", ResultW, 32'h1234_5678);

        // address wrap: 0x104 aliases word 1 (0x4) in a 64-word memory
        set_m(1'b0, 1'b1, 2'b00, 5'd0, 32'h104, 32'hCAFE_0000, 32'h0);
        tick();
        set_m(1'b1, 1'b0, 2'b01, 5'd8, 32'h4, 32'h0, 32'h0);
        tick();
        chk("wrap_rdw", 32'(RDW), 32'd8);
        chk("wrap_result", ResultW, 32'hCAFE_0000);

        // MMIO lw x7 @0x4000_0004, ack in the 4th cycle
        set_m(1'b1, 1'b0, 2'b01, 5'd7, 32'h4000_0004, 32'h0, 32'h0);
        @(negedge clk);
        chk("mmio_stall_c1", 32'(StallM), 32'd1);
        chk("mmio_req", 32'(bus_if.bus_req), 32'd1);
        chk("mmio_we", 32'(bus_if.bus_we), 32'd0);
        chk("mmio_addr", bus_if.bus_addr, 32'h4000_0004);
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mmio_stall_wait", 32'(StallM), 32'd1);
            chk("mmio_bubble", 32'(RegWriteW), 32'd0);
            tick();
        end
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'hA5A5_0001;
        @(negedge clk);
        chk("mmio_ack_stall", 32'(StallM), 32'd0);
        chk("mmio_ack_bubble", 32'(RegWriteW), 32'd0);
        tick();
        bus_if.bus_ack = 1'b0;
        chk("mmio_regwrite", 32'(RegWriteW), 32'd1);
        chk("mmio_rdw", 32'(RDW), 32'd7);
        chk("mmio_result", ResultW, 32'hA5A5_0001);

        // MMIO sw acked in the same cycle: no stall, no local write to word 4
        set_m(1'b0, 1'b1, 2'b00, 5'd0, 32'h4000_0010, 32'h0000_0077, 32'h0);
        bus_if.bus_ack = 1'b1;
        @(negedge clk);
        chk("msw_stall", 32'(StallM), 32'd0);
        chk("msw_req", 32'(bus_if.bus_req), 32'd1);
        chk("msw_we", 32'(bus_if.bus_we), 32'd1);
        chk("msw_wdata", bus_if.bus_wdata, 32'h0000_0077);
        tick();
        bus_if.bus_ack = 1'b0;
        set_m(1'b1, 1'b0, 2'b01, 5'd9, 32'h10, 32'h0, 32'h0);
        tick();
        chk("msw_no_local", ResultW, 32'h1234_5678);

        // jal link value
        set_m(1'b1, 1'b0, 2'b10, 5'd1, 32'h4000_0000, 32'h0, 32'h108);
        tick();
        chk("jal_rdw", 32'(RDW), 32'd1);
        chk("jal_result", ResultW, 32'h108);

        // add with MMIO-range result: no bus access
        set_m(1'b1, 1'b0, 2'b00, 5'd2, 32'h4000_0000, 32'h0, 32'h0);
        @(negedge clk);
        chk("add_req", 32'(bus_if.bus_req), 32'd0);
        chk("add_stall", 32'(StallM), 32'd0);
        tick();
        chk("add_result", ResultW, 32'h4000_0000);

        // ResultSrc 11 selects zero
        set_m(1'b1, 1'b0, 2'b11, 5'd3, 32'h55, 32'h0, 32'h77);
        tick();
        chk("src11_result", ResultW, 32'h0);

        // reset during WAIT
        set_m(1'b1, 1'b0, 2'b00, 5'd4, 32'h99, 32'h0, 32'h0);
        tick();
        set_m(1'b1, 1'b0, 2'b01, 5'd5, 32'h4000_0008, 32'h0, 32'h0);
        @(negedge clk);
        chk("rw_stall_pre", 32'(StallM), 32'd1);
        tick();
        @(negedge clk);
        chk("rw_req_wait", 32'(bus_if.bus_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rw_req", 32'(bus_if.bus_req), 32'd0);
        chk("rw_stall", 32'(StallM), 32'd0);
        chk("rw_regwrite", 32'(RegWriteW), 32'd0);
        chk("rw_rdw", 32'(RDW), 32'd0);
        chk("rw_result", ResultW, 32'h0);
        set_m(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        rst = 1'b1;
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rw_ign_req", 32'(bus_if.bus_req), 32'd0);
        chk("rw_ign_stall", 32'(StallM), 32'd0);
        tick();
        bus_if.bus_ack = 1'b0;
        chk("rw_ign_regwrite", 32'(RegWriteW), 32'd0);
        set_m(1'b1, 1'b0, 2'b01, 5'd9, 32'h10, 32'h0, 32'h0);
        tick();
        chk("rw_lw_regwrite", 32'(RegWriteW), 32'd1);
        chk("rw_lw_result", ResultW, 32'h1234_5678);

        // long MMIO wait with no ack
        set_m(1'b1, 1'b0, 2'b01, 5'd10, 32'h4000_000C, 32'h0, 32'h0);
`ifdef MEM_WB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_stall", 32'(StallM), 32'd1);
            chk("to_err_low", 32'(bus_if.bus_err), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("to_err", 32'(bus_if.bus_err), 32'd1);
        chk("to_stall_drop", 32'(StallM), 32'd0);
        tick();
        set_m(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
        chk("to_regwrite", 32'(RegWriteW), 32'd1);
        chk("to_result", ResultW, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("to_err_pulse", 32'(bus_if.bus_err), 32'd0);
`else
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("nto_stall", 32'(StallM), 32'd1);
            chk("nto_err", 32'(bus_if.bus_err), 32'd0);
            tick();
        end
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h1234_ABCD;
        tick();
        bus_if.bus_ack = 1'b0;
        set_m(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
        chk("nto_regwrite", 32'(RegWriteW), 32'd1);
        chk("nto_result", ResultW, 32'h1234_ABCD);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
